// File: rtl/ram_sp_arbiter.sv
// Two-port arbiter in front of a single-port asynchronous RAM: IDLE -> ACCESS -> RESP per transfer.
// Define RAM_SP_ARB_ROUND_ROBIN_EN for round-robin tie-breaking; otherwise port 0 wins ties.
//
// state  | meaning
// IDLE   | waiting for req0/req1; grant and latch request on the edge
// ACCESS | RAM cycle: chip select, address and write data or output enable
// RESP   | bus released, ack pulse to the granted port
module ram_sp_arbiter #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  wr0,
  input  logic                  wr1,
  input  logic [ADDR_WIDTH-1:0] addr0,
  input  logic [ADDR_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  ack0,
  output logic                  ack1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic                  ram_cs,
  output logic                  ram_we,
  output logic                  ram_oe,
  inout  wire  [DATA_WIDTH-1:0] ram_data
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic                    grant_q, grant_d;
  logic                    pick;
  logic                    take;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    ack0_d, ack1_d, busy_d;
  logic                    cs_d, we_d, oe_d;
  logic [ADDR_WIDTH-1:0]   addr_d;
  logic [DATA_WIDTH-1:0]   rdata_d;

`ifdef RAM_SP_ARB_ROUND_ROBIN_EN
  logic last_q;

  // On a tie the port that did not win last time goes next.
  always_comb begin
    pick = req1;
    if (req0 && req1) pick = ~last_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    last_q <= 1'b1;
    else if (take) last_q <= pick;
  end
`else
  always_comb begin
    pick = ~req0;
  end
`endif

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    wdata_d = wdata_q;
    take    = 1'b0;
    ack0_d  = 1'b0;
    ack1_d  = 1'b0;
    cs_d    = 1'b0;
    we_d    = 1'b0;
    oe_d    = 1'b0;
    addr_d  = ram_address;
    rdata_d = rdata;
    case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          take    = 1'b1;
          grant_d = pick;
          state_d = ACCESS;
          cs_d    = 1'b1;
          we_d    = pick ? wr1 : wr0;
          oe_d    = ~(pick ? wr1 : wr0);
          addr_d  = pick ? addr1 : addr0;
          wdata_d = pick ? wdata1 : wdata0;
        end
      end
      ACCESS: begin
        state_d = RESP;
        if (ram_oe) rdata_d = ram_data;
        ack0_d  = ~grant_q;
        ack1_d  = grant_q;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      grant_q     <= 1'b0;
      wdata_q     <= '0;
      ack0        <= 1'b0;
      ack1        <= 1'b0;
      busy        <= 1'b0;
      ram_cs      <= 1'b0;
      ram_we      <= 1'b0;
      ram_oe      <= 1'b0;
      ram_address <= '0;
      rdata       <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      wdata_q     <= wdata_d;
      ack0        <= ack0_d;
      ack1        <= ack1_d;
      busy        <= busy_d;
      ram_cs      <= cs_d;
      ram_we      <= we_d;
      ram_oe      <= oe_d;
      ram_address <= addr_d;
      rdata       <= rdata_d;
    end
  end

  // Drive only on a write cycle; the RAM owns the bus whenever ram_oe is high.
  assign ram_data = (ram_we && !ram_oe) ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_ram_sp_arbiter.sv
// Testbench for ram_sp_arbiter: behavioural RAM, transaction-level reference memory and arbitration rule.
module tb_ram_sp_arbiter;
  localparam int DW = 8;
  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0, req1, wr0, wr1;
  logic [AW-1:0] addr0, addr1;
  logic [DW-1:0] wdata0, wdata1;
  logic          ack0, ack1, busy, ram_cs, ram_we, ram_oe;
  logic [DW-1:0] rdata;
  logic [AW-1:0] ram_address;
  wire  [DW-1:0] ram_data;

  int n_cmp  = 0;
  int n_fail = 0;

  ram_sp_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .wr0(wr0), .wr1(wr1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .ack0(ack0), .ack1(ack1), .rdata(rdata), .busy(busy),
    .ram_address(ram_address), .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe),
    .ram_data(ram_data)
  );

  always #5 clk = ~clk;

  // Asynchronous-read RAM, written on the posedge while selected for write.
  logic [DW-1:0] mem [256];
  logic          preload;
  always @(posedge clk) begin
    if (preload) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else if (ram_cs && ram_we) begin
      mem[ram_address] <= ram_data;
    end
  end
  assign ram_data = (ram_cs && ram_oe) ? mem[ram_address] : 'z;

  // Reference model: expected memory contents, read result and last granted port.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_rdata;
  bit            exp_last;

  function automatic bit arb(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef RAM_SP_ARB_ROUND_ROBIN_EN
      return !exp_last;
`else
      return 1'b0;
`endif
    end
    return r1;
  endfunction

  // Per-cycle protocol checks.
  logic prev_ack0 = 1'b0, prev_ack1 = 1'b0;
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      n_cmp++;
      if (ram_we && ram_oe) begin
        n_fail++; $display("FAIL we_oe_overlap: we=%b oe=%b, required not both high", ram_we, ram_oe);
      end
      n_cmp++;
      if (ack0 && ack1) begin
        n_fail++; $display("FAIL ack_overlap: ack0=%b ack1=%b, required not both high", ack0, ack1);
      end
      n_cmp++;
      if ((ack0 && prev_ack0) || (ack1 && prev_ack1)) begin
        n_fail++; $display("FAIL ack_width: ack held two cycles (ack0=%b ack1=%b), required one cycle", ack0, ack1);
      end
      if (ram_cs && ram_oe) begin
        n_cmp++;
        if (ram_data !== mem[ram_address]) begin
          n_fail++; $display("FAIL bus_contention: ram_data=%h during read, required %h", ram_data, mem[ram_address]);
        end
      end
    end
    prev_ack0 <= ack0;
    prev_ack1 <= ack1;
  end

  task automatic set_req(input int p, input bit r, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (p == 0) begin req0 = r; wr0 = w; addr0 = a; wdata0 = d; end
    else        begin req1 = r; wr1 = w; addr1 = a; wdata1 = d; end
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    exp_last  = 1'b1;
    exp_rdata = '0;
  endtask

  // Single access from idle; returns with the DUT idle again.
  task automatic do_access(input int p, input bit w, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int lat = 0; bit got = 0; int wcnt = 0; bit busy_ok = 0;
    set_req(p, 1, w, a, d);
    while (!got && lat < 8) begin
      @(negedge clk); lat++;
      if (lat == 1) busy_ok = busy && ram_cs && (ram_address === a);
      if (ram_cs && ram_we && ram_data === d && ram_address === a) wcnt++;
      if (ack0 || ack1) got = 1;
    end
    n_cmp++;
    if (!got || lat != 2) begin
      n_fail++; $display("FAIL latency p%0d: ack after %0d cycles (seen=%b), required 2", p, lat, got);
    end
    n_cmp++;
    if (!busy_ok) begin
      n_fail++; $display("FAIL access_cycle p%0d: busy/cs/address wrong in ACCESS, required busy=1 cs=1 addr=%h", p, a);
    end
    n_cmp++;
    if ({ack1, ack0} !== ((p == 0) ? 2'b01 : 2'b10)) begin
      n_fail++; $display("FAIL ack_port: {ack1,ack0}=%b, required port %0d", {ack1, ack0}, p);
    end
    if (w) begin
      ref_mem[a] = d;
      n_cmp++;
      if (wcnt != 1) begin
        n_fail++; $display("FAIL write_pulse: write cycles with data %h = %0d, required 1", d, wcnt);
      end
    end else begin
      exp_rdata = ref_mem[a];
    end
    n_cmp++;
    if (rdata !== exp_rdata) begin
      n_fail++; $display("FAIL rdata p%0d addr %h: got %h, required %h", p, a, rdata, exp_rdata);
    end
    exp_last = p[0];
    set_req(p, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack0, ack1, busy, ram_cs, ram_we, ram_oe} !== 6'b0 || ram_address !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL reset_values: ctl=%b addr=%h rdata=%h, required all zero",
                         {ack0, ack1, busy, ram_cs, ram_we, ram_oe}, ram_address, rdata);
    end
    apply_reset();
    @(negedge clk);
    n_cmp++;
    if ({ack0, ack1, busy, ram_cs} !== 4'b0) begin
      n_fail++; $display("FAIL idle_after_reset: ack0/ack1/busy/cs=%b, required 0000", {ack0, ack1, busy, ram_cs});
    end
  endtask

  task automatic test_port0_rw();
    do_access(0, 1, 8'h12, 8'hA5);
    do_access(0, 0, 8'h12, 8'h00);
  endtask

  task automatic test_wrap();
    do_access(1, 1, 8'hFF, 8'h3C);
    do_access(1, 0, 8'hFF, 8'h00);
  endtask

  task automatic test_reset_mid_access();
    set_req(0, 1, 1, 8'h05, 8'h77);
    @(negedge clk);
    n_cmp++;
    if (!(ram_cs && ram_we)) begin
      n_fail++; $display("FAIL mid_access_setup: cs=%b we=%b, required 1 1", ram_cs, ram_we);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({ack0, ack1, busy, ram_cs, ram_we, ram_oe} !== 6'b0 || ram_address !== '0 || rdata !== '0) begin
      n_fail++; $display("FAIL async_reset: ctl=%b addr=%h rdata=%h, required all zero",
                         {ack0, ack1, busy, ram_cs, ram_we, ram_oe}, ram_address, rdata);
    end
    set_req(0, 0, 0, '0, '0);
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (ack0 || ack1) begin
        n_fail++; $display("FAIL abandoned_ack: ack0=%b ack1=%b, required 0 0", ack0, ack1);
      end
    end
    rst_n = 1'b1;
    exp_last  = 1'b1;
    exp_rdata = '0;
    do_access(0, 0, 8'h05, 8'h00);
  endtask

  task automatic test_arbitration();
    int lat; bit got; bit gp; bit ep;
    apply_reset();
    set_req(0, 1, 0, 8'h12, 8'h00);
    set_req(1, 1, 0, 8'hFF, 8'h00);
    for (int g = 0; g < 4; g++) begin
      ep = arb(1'b1, 1'b1);
      lat = 0; got = 0;
      while (!got && lat < 8) begin
        @(negedge clk); lat++;
        if (ack0 || ack1) got = 1;
      end
      gp = ack1;
      n_cmp++;
      if (!got || lat != ((g == 0) ? 2 : 3) || gp != ep) begin
        n_fail++; $display("FAIL grant_order #%0d: port %0d after %0d cycles (seen=%b), required port %0d after %0d",
                           g, gp, lat, got, ep, (g == 0) ? 2 : 3);
      end
      exp_rdata = ref_mem[ep ? 8'hFF : 8'h12];
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_fail++; $display("FAIL arb_rdata #%0d: got %h, required %h", g, rdata, exp_rdata);
      end
      exp_last = ep;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    @(negedge clk);
  endtask

  task automatic test_withdraw();
    int lat = 0; bit got = 0;
    set_req(1, 1, 1, 8'h40, 8'h99);
    @(negedge clk); lat++;
    set_req(1, 0, 0, 8'h41, 8'h11);
    while (!got && lat < 8) begin
      @(negedge clk); lat++;
      if (ack0 || ack1) got = 1;
    end
    n_cmp++;
    if (!got || !ack1 || lat != 2) begin
      n_fail++; $display("FAIL withdraw_ack: ack1=%b after %0d cycles (seen=%b), required ack1 after 2", ack1, lat, got);
    end
    ref_mem[8'h40] = 8'h99;
    exp_last = 1'b1;
    @(negedge clk);
    do_access(1, 0, 8'h40, 8'h00);
    do_access(0, 0, 8'h41, 8'h00);
  endtask

  task automatic test_random();
    bit pend [2]; bit pw [2]; logic [AW-1:0] pa [2]; logic [DW-1:0] pd [2];
    bit first = 1; int lat; bit got; bit ep;
    pend[0] = 0; pend[1] = 0;
    for (int it = 0; it < 80; it++) begin
      for (int p = 0; p < 2; p++) begin
        if (!pend[p] && ($urandom_range(0, 1) == 1)) begin
          pend[p] = 1; pw[p] = 1'($urandom); pa[p] = 8'($urandom); pd[p] = 8'($urandom);
          set_req(p, 1, pw[p], pa[p], pd[p]);
        end
      end
      if (!pend[0] && !pend[1]) begin
        pend[0] = 1; pw[0] = 1'($urandom); pa[0] = 8'($urandom); pd[0] = 8'($urandom);
        set_req(0, 1, pw[0], pa[0], pd[0]);
      end
      ep = arb(pend[0], pend[1]);
      lat = 0; got = 0;
      while (!got && lat < 8) begin
        @(negedge clk); lat++;
        if (ack0 || ack1) got = 1;
      end
      n_cmp++;
      if (!got || lat != (first ? 2 : 3) || {ack1, ack0} !== (ep ? 2'b10 : 2'b01)) begin
        n_fail++; $display("FAIL random_grant #%0d: {ack1,ack0}=%b after %0d cycles, required port %0d after %0d",
                           it, {ack1, ack0}, lat, ep, first ? 2 : 3);
      end
      if (pw[ep]) ref_mem[pa[ep]] = pd[ep];
      else        exp_rdata = ref_mem[pa[ep]];
      n_cmp++;
      if (rdata !== exp_rdata) begin
        n_fail++; $display("FAIL random_rdata #%0d: got %h, required %h (port %0d %s addr %h)",
                           it, rdata, exp_rdata, ep, pw[ep] ? "write" : "read", pa[ep]);
      end
      exp_last = ep;
      pend[ep] = 0;
      set_req(ep, 0, 1'($urandom), 8'($urandom), 8'($urandom));
      first = 0;
    end
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    exp_last  = 1'b1;
    exp_rdata = '0;
    rst_n     = 1'b0;
    set_req(0, 0, 0, '0, '0);
    set_req(1, 0, 0, '0, '0);
    preload = 1'b1;
    repeat (2) @(negedge clk);
    preload = 1'b0;
    test_reset();
    test_port0_rw();
    test_wrap();
    test_reset_mid_access();
    test_arbitration();
    test_withdraw();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule

// File: doc/ram_sp_arbiter.md
RAM_SP_ARBITER -- requirements
Module: ram_sp_arbiter

Interface
REQ-001 Parameters SHALL be:
- DATA_WIDTH, default 8, data bus width.
- ADDR_WIDTH, default 8, address width.
REQ-002 Ports SHALL be:
- clk  input  1  single clock; all state changes on posedge.
- rst_n  input  1  reset, asynchronous, active-low.
- req0 / req1  input  1  access request, port 0 / port 1.
- wr0 / wr1  input  1  operation, 1=write, 0=read.
- addr0 / addr1  input  ADDR_WIDTH  access address.
- wdata0 / wdata1  input  DATA_WIDTH  write data.
- ack0 / ack1  output  1  one-cycle completion pulse.
- rdata  output  DATA_WIDTH  read result, shared by both ports.
- busy  output  1  high in any state other than IDLE.
- ram_address  output  ADDR_WIDTH  RAM address.
- ram_cs  output  1  RAM chip select.
- ram_we  output  1  RAM write enable.
- ram_oe  output  1  RAM output enable.
- ram_data  inout  DATA_WIDTH  bidirectional RAM data bus.

Function
REQ-003 FSM states SHALL be IDLE, ACCESS and RESP; all outputs SHALL be registered except ram_data tri-state control, which SHALL be decoded from registered ram_we/ram_oe.
REQ-004 IDLE: if any reqN is high at a posedge, the FSM SHALL grant one port, latch its wrN/addrN/wdataN and enter ACCESS; with no request it SHALL stay in IDLE.
REQ-005 ACCESS (exactly 1 cycle): ram_cs=1 and ram_address=latched address; write: ram_we=1, ram_oe=0, ram_data driven with latched wdata; read: ram_we=0, ram_oe=1, ram_data high-Z.
REQ-006 Read data SHALL be sampled from ram_data at the posedge ending ACCESS into rdata; rdata SHALL hold until the next read completes and SHALL not change on writes.
REQ-007 RESP (exactly 1 cycle): ram_cs=ram_we=ram_oe=0, bus released, ackN=1 for the granted port only; next state IDLE.
REQ-008 Latency: request sampled in IDLE at edge k -> ACCESS in cycle k+1 -> ack in cycle k+2; back-to-back accesses SHALL therefore occur every 3 cycles minimum.
REQ-009 The controller SHALL never drive ram_data while ram_oe=1, and SHALL never assert ram_we and ram_oe together.
REQ-010 Requesters SHALL hold req/wr/addr/wdata stable until ack; inputs SHALL be sampled only in IDLE; later changes SHALL be ignored.
REQ-011 A req withdrawn after grant SHALL NOT abort the access; ack SHALL still pulse.
REQ-012 A req still high in the cycle after ack SHALL be treated as a new request.
REQ-013 Arbitration, simultaneous req0 and req1: the port not granted last SHALL win (see REQ-017); a lone requester SHALL always be granted.

Reset
REQ-014 On rst_n low, asynchronously: state=IDLE, ack0=ack1=0, busy=0, ram_cs=ram_we=ram_oe=0, ram_address=0, ram_data high-Z, rdata=0, last-grant pointer=port 1 (port 0 wins first tie).
REQ-015 Reset during ACCESS SHALL abandon the access with no ack; a write interrupted before its ending posedge SHALL NOT reach the RAM.
REQ-016 After rst_n deasserts, the first grant SHALL occur no earlier than the first posedge with rst_n high.

Configuration
REQ-017 With macro RAM_SP_ARB_ROUND_ROBIN_EN defined, ties SHALL resolve round-robin (REQ-013); undefined, port 0 SHALL always win ties (fixed priority) and the last-grant pointer SHALL be omitted.

Verification
REQ-018 Port 0 write addr=0x12 data=0xA5, then port 0 read addr=0x12 -> ack0 on cycles k+2 of each, rdata=0xA5, ack1 never high.
REQ-019 req0 and req1 both held high for 4 grants (ROUND_ROBIN_EN) -> grant order 0,1,0,1; without macro -> 0,0,0,0 while req0 held.
REQ-020 Port 1 write 0x3C to 0xFF (address wrap max) -> ram_cs=ram_we=1 and ram_data=0x3C for exactly one cycle; subsequent read of 0xFF returns 0x3C.
REQ-021 Assert rst_n low mid-ACCESS of a write 0x77 to 0x05 -> outputs to reset values immediately, no ack; later read of 0x05 does not return 0x77 (prior content 0x00 after preload).
REQ-022 Every cycle check: never (ram_we and ram_oe), never controller-driven ram_data while ram_oe=1, ack0 and ack1 never high together, each ack exactly one cycle wide.
